// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the 4-bit restoring divider.
// Imported by the control unit, its interface and the divider top.
package divider_pkg;

  localparam int DIV_N_BITS = 4;
  localparam int DIV_CNT_W  = 3;

  localparam logic SEL_SUB  = 1'b0;
  localparam logic SEL_ZERO = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CHECK   = 3'd2,
    SHIFT   = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_e;

endpackage

// File: rtl/divider_control_unit_if.sv
// System handshake plus datapath flag/control bundle of the divider.
// master = control unit, slave = datapath and system side.
interface divider_control_unit_if #(
  parameter int CNT_W = 3
);

  logic             go;
  logic             busy;
  logic             done;
  logic             err;

  logic             R_lt_Y;
  logic             cnt_out;
  logic             zeroerror;

  logic             Yen;
  logic             Xen;
  logic             Ren;
  logic             X_sL;
  logic             Xshiftbit;
  logic             RsL;
  logic             RsR;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             load_cnt;
  logic             ud;
  logic             Cen;
  logic [CNT_W-1:0] n;

  modport master (
    input  go, R_lt_Y, cnt_out, zeroerror,
    output busy, done, err,
    output Yen, Xen, Ren, X_sL, Xshiftbit,
    output RsL, RsR, s1, s2, s3,
    output load_cnt, ud, Cen, n
  );

  modport slave (
    output go, R_lt_Y, cnt_out, zeroerror,
    input  busy, done, err,
    input  Yen, Xen, Ren, X_sL, Xshiftbit,
    input  RsL, RsR, s1, s2, s3,
    input  load_cnt, ud, Cen, n
  );

endinterface

// File: rtl/divider_control_unit.sv
// Control FSM for the restoring divider: load, zero check,
// shift/compare iterations and result presentation.
module divider_control_unit
  import divider_pkg::*;
#(
  parameter int N_BITS = DIV_N_BITS,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  divider_control_unit_if.master  bus
);

  localparam logic [CNT_W-1:0] N_LOAD = CNT_W'(N_BITS);

  state_e state_q, state_d;
  logic   go_q, go_d;
  logic   start;

  assign go_d  = bus.go;
  assign start = bus.go & ~go_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
    end
  end

  // Mealy outputs: flags only matter in CHECK, SHIFT and COMPARE
  always_comb begin
    state_d       = state_q;
    bus.Yen       = 1'b0;
    bus.Xen       = 1'b0;
    bus.Ren       = 1'b0;
    bus.X_sL      = 1'b0;
    bus.Xshiftbit = 1'b0;
    bus.RsL       = 1'b0;
    bus.RsR       = 1'b0;
    bus.s1        = SEL_SUB;
    bus.s2        = 1'b1;
    bus.s3        = 1'b1;
    bus.load_cnt  = 1'b0;
    bus.ud        = 1'b0;
    bus.Cen       = 1'b0;
    bus.n         = N_LOAD;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        bus.busy     = 1'b1;
        bus.Yen      = 1'b1;
        bus.Xen      = 1'b1;
        bus.Ren      = 1'b1;
        bus.s1       = SEL_ZERO;
        bus.Cen      = 1'b1;
        bus.load_cnt = 1'b1;
        state_d      = CHECK;
      end
      CHECK: begin
        bus.busy = 1'b1;
        state_d  = bus.zeroerror ? ERR : SHIFT;
      end
      SHIFT: begin
        bus.busy = 1'b1;
        if (bus.cnt_out) begin
          state_d = DONE;
        end else begin
          bus.RsL = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        bus.busy = 1'b1;
        bus.X_sL = 1'b1;
        bus.Cen  = 1'b1;
        bus.ud   = 1'b0;
        if (!bus.R_lt_Y) begin
          bus.Ren       = 1'b1;
          bus.s1        = SEL_SUB;
          bus.Xshiftbit = 1'b1;
        end
        state_d = SHIFT;
      end
      DONE: begin
        bus.s2   = 1'b0;
        bus.s3   = 1'b0;
        bus.done = 1'b1;
        if (start) state_d = LOAD;
      end
      ERR: begin
        bus.err = 1'b1;
        if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_divider_control_unit.sv
// Directed bench: control unit plus a behavioural restoring datapath,
// with optional forcing of the datapath flags.
module tb_divider_control_unit;
  import divider_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divider_control_unit_if #(.CNT_W(DIV_CNT_W)) bus ();

  divider_control_unit #(
    .N_BITS(DIV_N_BITS),
    .CNT_W (DIV_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  logic [3:0] x_in, y_in, x_r, y_r;
  logic [4:0] r_r;
  logic [2:0] cnt_r;
  logic       force_en, f_lt, f_cnt, f_zero;
  logic [3:0] q_out, r_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r   <= '0;
      y_r   <= '0;
      r_r   <= '0;
      cnt_r <= '0;
    end else begin
      if (bus.Yen) y_r <= y_in;
      if (bus.Xen) x_r <= x_in;
      else if (bus.X_sL) x_r <= {x_r[2:0], bus.Xshiftbit};
      if (bus.Ren) r_r <= bus.s1 ? 5'd0 : r_r - {1'b0, y_r};
      else if (bus.RsL) r_r <= {r_r[3:0], x_r[3]};
      if (bus.Cen)
        cnt_r <= bus.load_cnt ? bus.n :
                 (bus.ud ? cnt_r + 3'd1 : cnt_r - 3'd1);
    end
  end

  assign bus.R_lt_Y    = force_en ? f_lt   : (r_r < {1'b0, y_r});
  assign bus.cnt_out   = force_en ? f_cnt  : (cnt_r == 3'd0);
  assign bus.zeroerror = force_en ? f_zero : (y_r == 4'd0);
  assign q_out = bus.s3 ? 4'd0 : x_r;
  assign r_out = bus.s2 ? 4'd0 : r_r[3:0];

  int vectors = 0;
  int miscompares = 0;

  // mode 0: go pulse, 1: go held high, 2: go toggled every cycle
  task automatic run_div(input logic [3:0] x, input logic [3:0] y,
                         input int mode, output int edges,
                         output logic [3:0] seq, output int ren_cmp,
                         output int ren_after, output int shl,
                         output int bad);
    x_in = x;
    y_in = y;
    bus.go = 1'b0;
    @(posedge clk); #1;
    bus.go = 1'b1;
    edges = 0; seq = '0; ren_cmp = 0;
    ren_after = 0; shl = 0; bad = 0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (bus.X_sL) begin
        seq = {seq[2:0], bus.Xshiftbit};
        if (bus.Ren) ren_cmp++;
      end
      if (bus.Ren && !bus.Yen) ren_after++;
      if (bus.X_sL || bus.RsL) shl++;
      if (bus.X_sL && bus.RsL && bus.Ren) bad++;
      if (bus.RsR) bad++;
      if ((bus.Yen || bus.Xen) && edges != 1) bad++;
      if (edges == 1 && !(bus.Yen && bus.Xen)) bad++;
      if (bus.done || bus.err) break;
      if (mode == 2) bus.go = ~bus.go;
      else if (mode == 0) bus.go = 1'b0;
    end
    if (mode != 1) bus.go = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_status: got %b want 000",
               {bus.busy, bus.done, bus.err});
    end
    vectors++;
    if ({bus.Yen, bus.Xen, bus.Ren, bus.X_sL, bus.RsL, bus.RsR,
         bus.s1, bus.load_cnt, bus.Cen, bus.ud} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_enables: got nonzero want 0");
    end
    vectors++;
    if ({bus.s2, bus.s3} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_s2s3: got %b want 11", {bus.s2, bus.s3});
    end
    vectors++;
    if (bus.n !== 3'd4) begin
      miscompares++;
      $display("FAIL reset_n: got %0d want 4", bus.n);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_div_13_3();
    int e, rc, ra, sh, bd;
    logic [3:0] sq;
    run_div(4'd13, 4'd3, 0, e, sq, rc, ra, sh, bd);
    vectors++;
    if (e !== 12 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL d13_latency: got %0d done=%b want 12 done=1",
               e, bus.done);
    end
    vectors++;
    if (q_out !== 4'd4 || r_out !== 4'd1) begin
      miscompares++;
      $display("FAIL d13_result: got Q=%0d R=%0d want Q=4 R=1",
               q_out, r_out);
    end
    vectors++;
    if (sq !== 4'b0100) begin
      miscompares++;
      $display("FAIL d13_qbits: got %b want 0100", sq);
    end
    vectors++;
    if (bd !== 0) begin
      miscompares++;
      $display("FAIL d13_rules: got %0d violations want 0", bd);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL d13_hold: got done=%b busy=%b want 1 0",
               bus.done, bus.busy);
    end
  endtask

  task automatic test_div_15_1();
    int e, rc, ra, sh, bd;
    logic [3:0] sq;
    run_div(4'd15, 4'd1, 0, e, sq, rc, ra, sh, bd);
    vectors++;
    if (q_out !== 4'd15 || r_out !== 4'd0) begin
      miscompares++;
      $display("FAIL d15_result: got Q=%0d R=%0d want Q=15 R=0",
               q_out, r_out);
    end
    vectors++;
    if (rc !== 4) begin
      miscompares++;
      $display("FAIL d15_ren: got %0d want 4", rc);
    end
  endtask

  task automatic test_div_2_7();
    int e, rc, ra, sh, bd;
    logic [3:0] sq;
    run_div(4'd2, 4'd7, 0, e, sq, rc, ra, sh, bd);
    vectors++;
    if (q_out !== 4'd0 || r_out !== 4'd2) begin
      miscompares++;
      $display("FAIL d2_result: got Q=%0d R=%0d want Q=0 R=2",
               q_out, r_out);
    end
    vectors++;
    if (ra !== 0) begin
      miscompares++;
      $display("FAIL d2_ren: got %0d want 0", ra);
    end
  endtask

  task automatic test_div_zero();
    int e, rc, ra, sh, bd;
    logic [3:0] sq;
    run_div(4'd9, 4'd0, 0, e, sq, rc, ra, sh, bd);
    vectors++;
    if (e !== 3 || bus.err !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_err: got edges=%0d err=%b done=%b want 3 1 0",
               e, bus.err, bus.done);
    end
    vectors++;
    if (sh !== 0 || q_out !== 4'd0) begin
      miscompares++;
      $display("FAIL dz_shift: got shifts=%0d Q=%0d want 0 0",
               sh, q_out);
    end
    run_div(4'd10, 4'd5, 0, e, sq, rc, ra, sh, bd);
    vectors++;
    if (e !== 12 || q_out !== 4'd2 || r_out !== 4'd0) begin
      miscompares++;
      $display("FAIL dz_recover: got e=%0d Q=%0d R=%0d want 12 2 0",
               e, q_out, r_out);
    end
  endtask

  task automatic test_go_held();
    int e, rc, ra, sh, bd, k;
    logic [3:0] sq;
    run_div(4'd6, 4'd2, 1, e, sq, rc, ra, sh, bd);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || q_out !== 4'd3) begin
      miscompares++;
      $display("FAIL held_norestart: got done=%b busy=%b Q=%0d want 1 0 3",
               bus.done, bus.busy, q_out);
    end
    bus.go = 1'b0;
    @(posedge clk); #1;
    bus.go = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.busy !== 1'b1 || bus.Yen !== 1'b1) begin
      miscompares++;
      $display("FAIL held_restart: got busy=%b Yen=%b want 1 1",
               bus.busy, bus.Yen);
    end
    k = 0;
    while (!bus.done && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    bus.go = 1'b0;
    vectors++;
    if (k !== 11 || q_out !== 4'd3) begin
      miscompares++;
      $display("FAIL held_second: got k=%0d Q=%0d want 11 3", k, q_out);
    end
  endtask

  task automatic test_go_toggle();
    int e, rc, ra, sh, bd;
    logic [3:0] sq;
    run_div(4'd13, 4'd3, 2, e, sq, rc, ra, sh, bd);
    vectors++;
    if (e !== 12 || q_out !== 4'd4 || r_out !== 4'd1 || sq !== 4'b0100) begin
      miscompares++;
      $display("FAIL toggle: got e=%0d Q=%0d R=%0d seq=%b want 12 4 1 0100",
               e, q_out, r_out, sq);
    end
  endtask

  task automatic test_forced_flags();
    force_en = 1'b1;
    f_zero = 1'b0; f_cnt = 1'b1; f_lt = 1'b1;
    bus.go = 1'b0;
    @(posedge clk); #1;
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b1 || bus.RsL !== 1'b0) begin
      miscompares++;
      $display("FAIL force_cnt_shift: got busy=%b RsL=%b want 1 0",
               bus.busy, bus.RsL);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL force_cnt_done: got %b want 1", bus.done);
    end
    f_cnt = 1'b0; f_lt = 1'b0;
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.RsL !== 1'b1 || bus.X_sL !== 1'b0) begin
      miscompares++;
      $display("FAIL force_shift: got RsL=%b X_sL=%b want 1 0",
               bus.RsL, bus.X_sL);
    end
    @(posedge clk); #1;
    vectors++;
    if ({bus.X_sL, bus.Ren, bus.s1, bus.Xshiftbit, bus.Cen, bus.ud,
         bus.RsL} !== 7'b1101100) begin
      miscompares++;
      $display("FAIL force_cmp_sub: got %b want 1101100",
               {bus.X_sL, bus.Ren, bus.s1, bus.Xshiftbit, bus.Cen,
                bus.ud, bus.RsL});
    end
    f_lt = 1'b1;
    #1;
    vectors++;
    if ({bus.X_sL, bus.Ren, bus.Xshiftbit, bus.Cen} !== 4'b1001) begin
      miscompares++;
      $display("FAIL force_cmp_keep: got %b want 1001",
               {bus.X_sL, bus.Ren, bus.Xshiftbit, bus.Cen});
    end
    f_cnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL force_end: got done=%b want 1", bus.done);
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    x_in = 4'd13; y_in = 4'd3;
    bus.go = 1'b0;
    @(posedge clk); #1;
    bus.go = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      bus.go = 1'b0;
      k++;
    end while (!bus.X_sL && k < 20);
    vectors++;
    if (k !== 4) begin
      miscompares++;
      $display("FAIL rmid_reach: got %0d want 4", k);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.err, bus.Yen, bus.Xen, bus.Ren,
         bus.X_sL, bus.RsL, bus.Cen, bus.load_cnt} !== 10'd0) begin
      miscompares++;
      $display("FAIL rmid_outputs: got nonzero want 0");
    end
    vectors++;
    if ({bus.s2, bus.s3} !== 2'b11) begin
      miscompares++;
      $display("FAIL rmid_s2s3: got %b want 11", {bus.s2, bus.s3});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_idle: got busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
  endtask

  initial begin
    bus.go = 1'b0;
    x_in = '0; y_in = '0;
    force_en = 1'b0; f_lt = 1'b0; f_cnt = 1'b0; f_zero = 1'b0;
    test_reset();
    test_div_13_3();
    test_div_15_1();
    test_div_2_7();
    test_div_zero();
    test_go_held();
    test_go_toggle();
    test_forced_flags();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divider_control_unit.md
Name: divider_control_unit

Overview:
- Control FSM for the 4-bit restoring divider datapath.
- Sequences operand load, divide-by-zero check, N shift/compare/subtract iterations and result presentation.
- Sits directly upstream of the datapath: consumes its flags (R_lt_Y, cnt_out, zeroerror) and drives every datapath enable, shift and select line.
- Presents a go/done/err handshake to the system.

Parameters:
- N_BITS, 4, number of quotient bits; value driven on n for the iteration counter load.
- CNT_W, 3, width of n; must satisfy 2^CNT_W > N_BITS.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- go  in  1  start request; level, rising edge detected internally
- R_lt_Y  in  1  datapath flag: R[3:0] < Y
- cnt_out  in  1  datapath flag: iteration counter == 0
- zeroerror  in  1  datapath flag: Y register == 0
- Yen, Xen, Ren  out  1 each  datapath register load enables
- X_sL  out  1  X shift-left enable
- Xshiftbit  out  1  bit inserted into X lsb on shift (quotient bit)
- RsL, RsR  out  1 each  R shift-left / shift-right enables
- s1  out  1  R_in select: 0 = subtractor, 1 = zero
- s2, s3  out  1 each  force R / Q outputs to zero when 1
- load_cnt, ud, Cen  out  1 each  counter load, direction (0 = down), enable
- n  out  CNT_W  counter load value, constant N_BITS
- busy  out  1  high in LOAD, CHECK, SHIFT, COMPARE
- done  out  1  high in DONE
- err  out  1  high in ERR

Behaviour:
- Start detection: go_q register; start = go & ~go_q; go_q resets to 0.
- States:
  - IDLE
  - LOAD
  - CHECK
  - SHIFT
  - COMPARE
  - DONE
  - ERR
- Defaults (all states unless overridden): every enable, shift and select line 0; s2 = s3 = 1; ud = 0; n = N_BITS.
- Reset: state = IDLE, go_q = 0; outputs equal defaults; busy = done = err = 0. Reset mid-operation aborts immediately to IDLE.
- IDLE: start -> LOAD.
- LOAD (1 cycle): Yen = Xen = 1; Ren = 1 with s1 = 1 (R cleared); Cen = load_cnt = 1. -> CHECK.
- CHECK (1 cycle): zeroerror -> ERR, else -> SHIFT. Y is sampled after the LOAD edge.
- SHIFT:
  - if cnt_out = 1: no datapath action, -> DONE.
  - else: RsL = 1 (R takes X msb), -> COMPARE.
- COMPARE:
  - X_sL = 1; Cen = 1 with ud = 0 (decrement).
  - if R_lt_Y = 0: Ren = 1, s1 = 0 (R <= R - Y), Xshiftbit = 1.
  - else: Xshiftbit = 0, R held.
  - -> SHIFT.
- DONE: s2 = s3 = 0 (R, Q visible), done = 1; start -> LOAD; otherwise hold indefinitely.
- ERR: err = 1, s2 = s3 = 1; start -> LOAD.
- Timing: go edge to done = 1 + 1 + 1 + 2*N_BITS + 1 cycles. With N_BITS = 4: start registered in IDLE, done asserted 12 cycles after the first go-high cycle.
- Control-line rules:
  - X_sL, RsL and Ren are never asserted together.
  - RsR is always 0.
  - Yen and Xen are asserted only in LOAD.
- go held high: no restart; a new rising edge is required. go rising in LOAD through COMPARE is ignored; the edge is consumed and not queued.
- Unused state encodings recover to IDLE on the next clock.
- All outputs are combinational from state, plus the listed flag inputs in CHECK, SHIFT and COMPARE (Mealy).

Decomposition:
- Shared package divider_pkg:
  - state localparams (IDLE = 0 … ERR = 6, 3-bit encoding)
  - N_BITS default
  - s1 select constants SEL_SUB = 0, SEL_ZERO = 1
- No sub-module; the edge detector is inline.
- Top-level divider_top (separate block) wires this unit to the datapath.

Test Plan:
- rst pulsed mid-COMPARE -> state IDLE same cycle, all enables 0, s2 = s3 = 1, busy = done = err = 0.
- Unit plus datapath, X = 13, Y = 3, go pulse -> done at cycle 12, Q = 4, R = 1. Xshiftbit sequence across COMPAREs = 0,1,0,0.
- X = 15, Y = 1 -> Q = 15, R = 0, Ren asserted in all 4 COMPAREs. X = 2, Y = 7 -> Q = 0, R = 2, Ren never asserted after LOAD.
- Y = 0, X = 9 -> ERR two cycles after start, err = 1, done = 0, no RsL/X_sL ever asserted. Next go edge with Y = 5, X = 10 -> Q = 2, R = 0.
- go held high through DONE -> no restart. Drop then raise go -> LOAD next cycle. go toggled during busy -> sequence and latency unchanged.
- Standalone with forced flags: cnt_out = 1 in SHIFT -> DONE with no RsL. R_lt_Y = 0 in COMPARE -> Ren = 1, s1 = 0, Xshiftbit = 1, Cen = 1, ud = 0 in that cycle.
